// File: rtl/sparse_conv_engine_pkg.sv
// Shared types and helpers for the sparse convolution engine.
// Latency: none (types, constant functions and a combinational saturate).
// Backpressure: not applicable.
package sparse_cnn_pkg;

  typedef enum logic [2:0] {
    CLEAR,
    IDLE,
    LOAD_W,
    RUN_WAIT,
    RUN_MAC,
    DRAIN
  } state_t;

  // Bits needed to index v entries; never returns less than 1.
  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = 1;
    while (x < v) begin
      x = x * 2;
      r++;
    end
    if (r < 1) r = 1;
    return r;
  endfunction

  // Valid-mode convolution output side length.
  function automatic int out_dim(input int data_dim, input int kernel);
    return data_dim - kernel + 1;
  endfunction

  // Clamp a signed value into the signed range of a w-bit result.
  function automatic longint sat_val(input longint v, input int w);
    longint mx;
    longint mn;
    longint r;
    mx = (longint'(1) <<< (w - 1)) - 1;
    mn = -mx - 1;
    if (v > mx)      r = mx;
    else if (v < mn) r = mn;
    else             r = v;
    return r;
  endfunction

endpackage

// File: rtl/sparse_conv_engine_if.sv
// Handshaked weight, feature and output streams of the sparse convolution engine.
// Latency: none (wiring only).
// Backpressure: valid/ready on every stream; master is the source/sink side, slave is the engine.
interface sparse_conv_engine_if #(
  parameter int DATA_W  = 8,
  parameter int COORD_W = 8,
  parameter int OUT_W   = 16
);
  logic                      w_valid;
  logic                      w_ready;
  logic signed [DATA_W-1:0]  w_value;
  logic [COORD_W-1:0]        w_row;
  logic [COORD_W-1:0]        w_col;
  logic                      w_last;

  logic                      f_valid;
  logic                      f_ready;
  logic signed [DATA_W-1:0]  f_value;
  logic [COORD_W-1:0]        f_row;
  logic [COORD_W-1:0]        f_col;
  logic                      f_last;

  logic                      o_valid;
  logic                      o_ready;
  logic signed [OUT_W-1:0]   o_data;
  logic [COORD_W-1:0]        o_row;
  logic [COORD_W-1:0]        o_col;
  logic                      o_last;

  modport master (
    output w_valid, w_value, w_row, w_col, w_last,
    output f_valid, f_value, f_row, f_col, f_last,
    output o_ready,
    input  w_ready, f_ready,
    input  o_valid, o_data, o_row, o_col, o_last
  );

  modport slave (
    input  w_valid, w_value, w_row, w_col, w_last,
    input  f_valid, f_value, f_row, f_col, f_last,
    input  o_ready,
    output w_ready, f_ready,
    output o_valid, o_data, o_row, o_col, o_last
  );
endinterface

// File: rtl/sparse_conv_engine_acc_buffer.sv
// Dense OUT_DIM^2 accumulator array: one RMW accumulate port, one read-and-clear port, clear sweep.
// Latency: reads are combinational; accumulate and clear land on the next clock edge.
// Backpressure: none; the caller sequences ports so they never target the same cycle meaningfully.
module sparse_acc_buffer
  import sparse_cnn_pkg::*;
#(
  parameter int ACC_W  = 24,
  parameter int NPIX   = 9,
  parameter int ADDR_W = clog2(NPIX)
) (
  input  logic                     clk,
  input  logic                     acc_en,
  input  logic [ADDR_W-1:0]        acc_addr,
  input  logic signed [ACC_W-1:0]  acc_val,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic signed [ACC_W-1:0]  rd_data,
  input  logic                     rd_clr,
  input  logic                     clr_en,
  input  logic [ADDR_W-1:0]        clr_addr
);
  logic signed [ACC_W-1:0] mem [NPIX];

  assign rd_data = mem[rd_addr];

  // Per-entry update: clearing wins over accumulation; the sum wraps modulo 2^ACC_W.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NPIX; i++) begin
      if ((clr_en && clr_addr == ADDR_W'(i)) || (rd_clr && rd_addr == ADDR_W'(i))) begin
        mem[i] <= '0;
      end else if (acc_en && acc_addr == ADDR_W'(i)) begin
        mem[i] <= mem[i] + acc_val;
      end
    end
  end
endmodule

// File: rtl/sparse_conv_engine.sv
// Sparse valid-mode 2-D convolution: COO weights x COO features scattered into a dense buffer, drained in raster order.
// Latency: one MAC per stored weight per feature (f_ready back nw+1 cycles after accept); drain one word per o handshake.
// Backpressure: valid/ready on all streams; outputs hold while o_ready=0. SPARSE_CONV_RELU_EN clamps drained values at 0.
module sparse_conv_engine
  import sparse_cnn_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int COORD_W  = 8,
  parameter int KERNEL   = 5,
  parameter int DATA_DIM = 28,
  parameter int ACC_W    = 24,
  parameter int OUT_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  sparse_conv_engine_if.slave   bus,
  output logic                  busy
);
  localparam int K2      = KERNEL * KERNEL;
  localparam int OUT_DIM = out_dim(DATA_DIM, KERNEL);
  localparam int NPIX    = OUT_DIM * OUT_DIM;
  localparam int ADDR_W  = clog2(NPIX);
  localparam int NW_W    = clog2(K2 + 1);
  localparam int WI_W    = clog2(K2);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);

  state_t                   state, state_nx;
  logic [NW_W-1:0]          nw, idx;
  logic [ADDR_W-1:0]        addr;
  logic [COORD_W-1:0]       o_row_q, o_col_q;

  logic signed [DATA_W-1:0] wv_q   [K2];
  logic [COORD_W-1:0]       wr_q   [K2];
  logic [COORD_W-1:0]       wc_q   [K2];
  logic signed [DATA_W-1:0] f_val_q;
  logic [COORD_W-1:0]       f_row_q, f_col_q;
  logic                     f_last_q;

  logic w_rdy, f_rdy, o_vld;
  logic w_hs, f_hs, o_hs;
  logic [WI_W-1:0] w_wr, cur;

  assign w_hs = bus.w_valid && w_rdy;
  assign f_hs = bus.f_valid && f_rdy;
  assign o_hs = o_vld && bus.o_ready;
  assign w_wr = (state == IDLE) ? '0 : nw[WI_W-1:0];
  assign cur  = idx[WI_W-1:0];

  // Next-state and handshake outputs.
  always_comb begin
    state_nx = state;
    w_rdy    = 1'b0;
    f_rdy    = 1'b0;
    o_vld    = 1'b0;
    busy     = 1'b0;
    case (state)
      CLEAR: begin
        busy = 1'b1;
        if (addr == LAST_ADDR) state_nx = IDLE;
      end
      IDLE: begin
        w_rdy = 1'b1;
        // A pending weight beat takes priority, so the feature is not consumed alongside it.
        f_rdy = (nw != '0) && !bus.w_valid;
        if (bus.w_valid) state_nx = (bus.w_last || K2 == 1) ? RUN_WAIT : LOAD_W;
        else if (f_hs)   state_nx = RUN_MAC;
      end
      LOAD_W: begin
        busy  = 1'b1;
        w_rdy = 1'b1;
        if (bus.w_valid && (bus.w_last || nw == NW_W'(K2 - 1))) state_nx = RUN_WAIT;
      end
      RUN_WAIT: begin
        f_rdy = 1'b1;
        if (bus.f_valid) state_nx = RUN_MAC;
      end
      RUN_MAC: begin
        busy = 1'b1;
        if (idx == nw - 1'b1) state_nx = f_last_q ? DRAIN : RUN_WAIT;
      end
      DRAIN: begin
        busy  = 1'b1;
        o_vld = 1'b1;
        if (bus.o_ready && addr == LAST_ADDR) state_nx = IDLE;
      end
      default: state_nx = CLEAR;
    endcase
  end

  // Control state: sweep/drain address, weight count, MAC index, raster coordinates.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      nw      <= '0;
      idx     <= '0;
      addr    <= '0;
      o_row_q <= '0;
      o_col_q <= '0;
    end else begin
      state <= state_nx;
      case (state)
        CLEAR:    addr <= (addr == LAST_ADDR) ? '0 : addr + 1'b1;
        IDLE: begin
          if (w_hs)      nw  <= NW_W'(1);
          else if (f_hs) idx <= '0;
        end
        LOAD_W:   if (w_hs) nw <= nw + 1'b1;
        RUN_WAIT: if (f_hs) idx <= '0;
        RUN_MAC:  idx <= idx + 1'b1;
        DRAIN: begin
          if (o_hs) begin
            if (addr == LAST_ADDR) begin
              addr    <= '0;
              o_row_q <= '0;
              o_col_q <= '0;
            end else begin
              addr <= addr + 1'b1;
              if (o_col_q == COORD_W'(OUT_DIM - 1)) begin
                o_col_q <= '0;
                o_row_q <= o_row_q + 1'b1;
              end else begin
                o_col_q <= o_col_q + 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Weight registers and the latched feature beat (data only, qualified by control state).
  always_ff @(posedge clk) begin
    if (w_hs) begin
      wv_q[w_wr] <= bus.w_value;
      wr_q[w_wr] <= bus.w_row;
      wc_q[w_wr] <= bus.w_col;
    end
    if (f_hs) begin
      f_val_q  <= bus.f_value;
      f_row_q  <= bus.f_row;
      f_col_q  <= bus.f_col;
      f_last_q <= bus.f_last;
    end
  end

  // Scatter target: output coordinate is feature position minus weight offset.
  logic signed [COORD_W:0]     orow, ocol;
  logic                        in_range;
  logic signed [2*DATA_W-1:0]  prod;
  logic [ADDR_W-1:0]           acc_addr;
  logic signed [ACC_W-1:0]     acc_val;
  logic signed [ACC_W-1:0]     rd_data;

  assign orow     = $signed({1'b0, f_row_q}) - $signed({1'b0, wr_q[cur]});
  assign ocol     = $signed({1'b0, f_col_q}) - $signed({1'b0, wc_q[cur]});
  assign in_range = !orow[COORD_W] && !ocol[COORD_W] &&
                    (orow[COORD_W-1:0] < COORD_W'(OUT_DIM)) &&
                    (ocol[COORD_W-1:0] < COORD_W'(OUT_DIM));
  assign prod     = f_val_q * wv_q[cur];
  assign acc_val  = ACC_W'(prod);
  assign acc_addr = ADDR_W'(int'(orow[COORD_W-1:0]) * OUT_DIM + int'(ocol[COORD_W-1:0]));

  sparse_acc_buffer #(
    .ACC_W  (ACC_W),
    .NPIX   (NPIX),
    .ADDR_W (ADDR_W)
  ) u_buf (
    .clk      (clk),
    .acc_en   (state == RUN_MAC && in_range),
    .acc_addr (acc_addr),
    .acc_val  (acc_val),
    .rd_addr  (addr),
    .rd_data  (rd_data),
    .rd_clr   (o_hs),
    .clr_en   (state == CLEAR),
    .clr_addr (addr)
  );

  // Drain value: saturate to OUT_W, optionally clamp negatives to zero.
  logic signed [OUT_W-1:0] sat_v, drain_v;
  assign sat_v = OUT_W'(sat_val(longint'(rd_data), OUT_W));
`ifdef SPARSE_CONV_RELU_EN
  assign drain_v = sat_v[OUT_W-1] ? '0 : sat_v;
`else
  assign drain_v = sat_v;
`endif

  assign bus.w_ready = w_rdy;
  assign bus.f_ready = f_rdy;
  assign bus.o_valid = o_vld;
  assign bus.o_data  = o_vld ? drain_v : '0;
  assign bus.o_row   = o_vld ? o_row_q : '0;
  assign bus.o_col   = o_vld ? o_col_q : '0;
  assign bus.o_last  = o_vld && (addr == LAST_ADDR);
endmodule

// File: tb/tb_sparse_conv_engine.sv
// Scoreboard bench for sparse_conv_engine with KERNEL=3, DATA_DIM=5 (3x3 output).
// Latency: expected frames are queued at issue time and popped on each output handshake.
// Backpressure: exercises steady and toggling o_ready, and checks outputs hold while stalled.
module tb_sparse_conv_engine;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;

  sparse_conv_engine_if #(.DATA_W(8), .COORD_W(8), .OUT_W(16)) bus ();

  sparse_conv_engine #(
    .DATA_W(8), .COORD_W(8), .KERNEL(3), .DATA_DIM(5), .ACC_W(24), .OUT_W(16)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus.slave),
    .busy (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int data;
    int row;
    int col;
    bit last;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: hold-stability while stalled, and scoreboard comparison on each handshake.
  logic        hold_pend = 1'b0;
  int          hold_data;
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (hold_pend) begin
        check("hold_valid", int'(bus.o_valid), 1);
        check("hold_data", int'($signed(bus.o_data)), hold_data);
      end
      hold_pend = bus.o_valid && !bus.o_ready;
      hold_data = int'($signed(bus.o_data));
      if (bus.o_valid && bus.o_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_output: got data=%0d row=%0d col=%0d with nothing expected",
                   $signed(bus.o_data), bus.o_row, bus.o_col);
        end else begin
          e = sb.pop_front();
          check("out_data", int'($signed(bus.o_data)), e.data);
          check("out_pos_last", int'({bus.o_row, bus.o_col, bus.o_last}),
                int'({8'(e.row), 8'(e.col), e.last}));
        end
      end
    end
  end

  // Queue a 3x3 frame that is zero except at up to two raster indices (-1 = unused).
  task automatic push_frame(input int i1, input int v1, input int i2, input int v2);
    for (int p = 0; p < 9; p++) begin
      exp_t e;
      e.data = (p == i1) ? v1 : ((p == i2) ? v2 : 0);
      e.row  = p / 3;
      e.col  = p % 3;
      e.last = (p == 8);
      sb.push_back(e);
    end
  endtask

  task automatic send_w(input int v, input int r, input int c, input bit last);
    int n = 0;
    bus.w_valid = 1'b1;
    bus.w_value = 8'(v);
    bus.w_row   = 8'(r);
    bus.w_col   = 8'(c);
    bus.w_last  = last;
    @(negedge clk);
    while (!bus.w_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.w_ready) begin
      total++;
      bad++;
      $display("FAIL w_handshake_timeout: w_ready=0 after %0d cycles, required 1", n);
    end
    @(posedge clk);
    #1 bus.w_valid = 1'b0;
  endtask

  task automatic send_f(input int v, input int r, input int c, input bit last);
    int n = 0;
    bus.f_valid = 1'b1;
    bus.f_value = 8'(v);
    bus.f_row   = 8'(r);
    bus.f_col   = 8'(c);
    bus.f_last  = last;
    @(negedge clk);
    while (!bus.f_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.f_ready) begin
      total++;
      bad++;
      $display("FAIL f_handshake_timeout: f_ready=0 after %0d cycles, required 1", n);
    end
    @(posedge clk);
    #1 bus.f_valid = 1'b0;
  endtask

  // Wait for the queued frame to drain, optionally toggling o_ready every cycle.
  task automatic wait_drain(input bit toggle);
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge clk);
      #1 if (toggle) bus.o_ready = ~bus.o_ready;
      n++;
    end
    check("drain_complete_left", sb.size(), 0);
    bus.o_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    bus.w_valid = 1'b0; bus.w_value = '0; bus.w_row = '0; bus.w_col = '0; bus.w_last = 1'b0;
    bus.f_valid = 1'b0; bus.f_value = '0; bus.f_row = '0; bus.f_col = '0; bus.f_last = 1'b0;
    bus.o_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Clear sweep: nine busy cycles with all handshakes closed, then idle.
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      check("clear_busy_wr_fr_ov", int'({busy, bus.w_ready, bus.f_ready, bus.o_valid}), 8);
      if (i == 0) begin
        check("reset_o_data", int'(bus.o_data), 0);
        check("reset_o_pos_last", int'({bus.o_row, bus.o_col, bus.o_last}), 0);
      end
    end
    @(negedge clk);
    check("idle_busy_wr", int'({busy, bus.w_ready}), 1);
    @(posedge clk);
    #1;

    // Single weight (0,0)=2; an out-of-map feature first, then (1,1)=3 last.
    push_frame(4, 6, -1, 0);
    send_w(2, 0, 0, 1'b1);
    send_f(1, 6, 6, 1'b0);
    @(negedge clk);
    check("f_ready_during_mac", int'(bus.f_ready), 0);
    @(negedge clk);
    check("f_ready_after_2", int'(bus.f_ready), 1);
    @(posedge clk);
    #1;
    send_f(3, 1, 1, 1'b1);
    wait_drain(1'b0);

    // Weight (1,1) against feature (0,0): every product falls outside the map.
    push_frame(-1, 0, -1, 0);
    send_w(1, 1, 1, 1'b1);
    send_f(5, 0, 0, 1'b1);
    wait_drain(1'b0);

    // Positive saturation: 3 x 127*127 = 48387 -> 32767.
    push_frame(8, 32767, -1, 0);
    send_w(127, 0, 0, 1'b1);
    send_f(127, 2, 2, 1'b0);
    send_f(127, 2, 2, 1'b0);
    send_f(127, 2, 2, 1'b1);
    wait_drain(1'b0);

    // Negative saturation with retained weight: 3 x 127*-128 = -48768 -> -32768.
    push_frame(8, -32768, -1, 0);
    send_f(-128, 2, 2, 1'b0);
    send_f(-128, 2, 2, 1'b0);
    send_f(-128, 2, 2, 1'b1);
    wait_drain(1'b0);

    // Two-beat weight set, drained under toggling o_ready: idx8=3*1, idx3=3*-2.
    push_frame(8, 3, 3, -6);
    send_w(1, 0, 0, 1'b0);
    send_w(-2, 1, 2, 1'b1);
    send_f(3, 2, 2, 1'b1);
    wait_drain(1'b1);

    // Same weights, fresh frame must start from zero: idx2=4, second weight lands off-map.
    push_frame(2, 4, -1, 0);
    send_f(4, 0, 2, 1'b1);
    wait_drain(1'b0);

    // Negative product: clamped to zero only when the ReLU option is built in.
`ifdef SPARSE_CONV_RELU_EN
    push_frame(0, 0, -1, 0);
`else
    push_frame(0, -4, -1, 0);
`endif
    send_w(-1, 0, 0, 1'b1);
    send_f(4, 0, 0, 1'b1);
    wait_drain(1'b0);

    check("idle_at_end_busy", int'(busy), 0);
    check("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/sparse_conv_engine.md
Name: sparse_conv_engine

Overview:
- Sequential sparse 2-D valid-mode convolution engine, next generation of the single-channel sparse PE top.
- Accepts COO-format nonzero weights (value,row,col), then a streamed frame of COO-format nonzero features.
- Scatter-accumulates every feature×weight product into an on-chip dense output buffer, then drains the buffer in raster order over a valid/ready stream.
- Replaces the flat whole-image input buses with handshaked streams; sits between the sparse encoder and the next layer's compressor.

Parameters:
- DATA_W, 8, signed feature/weight value width
- COORD_W, 8, unsigned row/col coordinate width
- KERNEL, 5, kernel side length; max nonzero weights = KERNEL*KERNEL
- DATA_DIM, 28, input feature map side; OUT_DIM = DATA_DIM-KERNEL+1 (localparam)
- ACC_W, 24, signed accumulator width
- OUT_W, 16, signed output width (saturated)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- w_valid/w_ready  in/out  1/1  weight stream handshake
- w_value  in  DATA_W  signed weight
- w_row, w_col  in  COORD_W  weight kernel coordinates
- w_last  in  1  final weight of set
- f_valid/f_ready  in/out  1/1  feature stream handshake
- f_value  in  DATA_W  signed feature
- f_row, f_col  in  COORD_W  feature coordinates
- f_last  in  1  final feature of frame
- o_valid/o_ready  out/in  1/1  output stream handshake
- o_data  out  OUT_W  saturated accumulated value
- o_row, o_col  out  COORD_W  output coordinates
- o_last  out  1  final output of frame
- busy  out  1  high in CLEAR, LOAD_W, RUN_MAC, DRAIN

Behaviour:
- States: CLEAR, IDLE, LOAD_W, RUN_WAIT, RUN_MAC, DRAIN.
- Reset (any time, including mid-frame): state=CLEAR, nw=0, all readies/o_valid/o_last=0, o_data/o_row/o_col=0, busy=1. CLEAR writes zero to one buffer address per cycle (OUT_DIM² cycles), then IDLE.
- IDLE: w_ready=1, f_ready=1 (if nw>0). If w_valid: new weight set, nw<=0, store beat, LOAD_W (or RUN_WAIT if w_last). Else if f_valid and nw>0: feature latched, RUN_MAC with current weights. w_valid wins when both valid.
- LOAD_W: w_ready=1; each handshake writes weight regs[nw], nw++. w_last, or the KERNEL²-th beat, ends load -> RUN_WAIT. Zero-valued weights are stored and used.
- RUN_WAIT: f_ready=1; handshake latches feature -> RUN_MAC, idx=0.
- RUN_MAC: one MAC per cycle for idx=0..nw-1: orow=f_row-w_row[idx], ocol=f_col-w_col[idx] (signed, COORD_W+1 bits); if 0<=orow,ocol<OUT_DIM, buf[orow*OUT_DIM+ocol] += sext(f_value*w_value[idx]) (product 2*DATA_W signed, sign-extended; accumulator wraps modulo 2^ACC_W); else product dropped. After idx=nw-1: DRAIN if latched f_last, else RUN_WAIT. Accepted at cycle t -> f_ready again at t+nw+1.
- Read-modify-write is single-cycle; no hazard between consecutive MACs.
- DRAIN: o_valid=1; o_data=sat(buf[addr]) to OUT_W signed range; o_row/o_col from addr; o_last at addr=OUT_DIM²-1. Outputs hold stable while o_ready=0. On handshake buf[addr]<=0, addr++; after last -> IDLE, weights retained.
- Features with coordinates >=DATA_DIM: processed normally; resulting out-of-range products are dropped.

Optional Feature:
- SPARSE_CONV_RELU_EN defined: DRAIN output is max(0,sat(buf[addr])); buffer still cleared.
- Undefined: signed saturated value passed unchanged.

Decomposition:
- Package sparse_cnn_pkg: state enum, clog2 function, signed saturate function, OUT_DIM/address-width derivation.
- Sub-module sparse_acc_buffer: OUT_DIM²×ACC_W flop array, one RMW accumulate port, one read-and-clear port, clear-sweep input.

Test Plan (KERNEL=3, DATA_DIM=5, OUT_DIM=3 unless stated):
- Reset -> busy=1, w_ready=f_ready=o_valid=0 for 9 cycles, then w_ready=1, busy=0.
- Weight (0,0)=2 last; feature (1,1)=3 last -> 9 outputs, raster index 4 = 6, others 0, o_last on 9th; f_ready returns 2 cycles after accept.
- Weight (1,1)=1; feature (0,0)=5 last -> all 9 outputs 0 (out-of-range dropped).
- Weight (0,0)=127; three features (2,2)=127, last on third -> index 8 = 32767 (48387 saturated); repeat with value -128 -> -32768.
- o_ready toggling every other cycle -> 9 values, none lost or duplicated; second frame with same weights starts from zero.
- SPARSE_CONV_RELU_EN: weight (0,0)=-1, feature (0,0)=4 -> output 0 with macro, -4 without.
